ps2_keymatrix: RTL and testbench
================================

PS2_KEYMATRIX -- requirements
Module: ps2_keymatrix

Interface
REQ-001 SHALL have parameter ROWS, default 16, the number of key-matrix rows (2..16).
REQ-002 SHALL have parameter COLS, default 8, the number of key-matrix columns (1..8).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000, the maximum clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-004 SHALL have parameter FILTER, default 4, the number of consecutive equal samples needed to accept a ps2_clk level change.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port ps2_clk, input, 1 bit: the asynchronous PS/2 clock line.
REQ-008 SHALL have port ps2_data, input, 1 bit: the asynchronous PS/2 data line.
REQ-009 SHALL have port kbd_adr, input, clog2(ROWS) bits: the row read address.
REQ-010 SHALL have port keydata, output, COLS bits: the registered row contents; a 1 bit means the key is pressed.
REQ-011 SHALL have port map_code, output, 9 bits: the lookup key {e0_flag, scan byte}.
REQ-012 SHALL have port map_row, input, clog2(ROWS) bits: the row returned by the external keymap.
REQ-013 SHALL have port map_col, input, clog2(COLS) bits: the column returned by the external keymap.
REQ-014 SHALL have port map_valid, input, 1 bit: the external keymap has an entry for map_code.
REQ-015 SHALL have port kbd_clear, input, 1 bit: synchronous clear of the whole matrix.
REQ-016 SHALL have port scan_valid, output, 1 bit: a one-cycle pulse when a good byte is received.
REQ-017 SHALL have port scan_code, output, 8 bits: the last good byte, held until the next good byte.
REQ-018 SHALL have port err_parity, output, 1 bit: a one-cycle pulse on a parity error.
REQ-019 SHALL have port err_frame, output, 1 bit: a one-cycle pulse on a bad start bit, a bad stop bit or a timeout.

Function
REQ-020 SHALL pass ps2_clk and ps2_data through 2-FF synchronisers, then accept a ps2_clk change only after FILTER equal samples.
REQ-021 SHALL sample data on each falling edge of the filtered ps2_clk.
REQ-022 SHALL receive 11-bit frames: start 0, data LSB first, odd parity, stop 1.
REQ-023 SHALL run a receiver FSM with states RX_IDLE -> RX_SHIFT -> RX_CHECK -> RX_IDLE; RX_IDLE leaves on a falling edge with data 0.
REQ-024 SHALL, in RX_CHECK (one cycle after the 11th edge), pulse scan_valid and update scan_code only if parity and stop are correct; otherwise it SHALL pulse err_parity or err_frame, leave the matrix and flags untouched, and return to RX_IDLE.
REQ-025 SHALL, in RX_SHIFT, pulse err_frame and return to RX_IDLE when the inter-edge counter reaches TIMEOUT_CYC; the counter clears on every falling edge.
REQ-026 SHALL run a decoder FSM with states D_IDLE -> D_LOOKUP -> D_WRITE -> D_IDLE, entered on scan_valid.
REQ-027 SHALL, for byte 0xE0, set e0_flag and return to D_IDLE with no lookup.
REQ-028 SHALL, for byte 0xF0, set brk_flag and return to D_IDLE with no lookup.
REQ-029 SHALL, for byte 0xE1, load a skip counter of 7 and discard the next 7 good bytes (Pause sequence).
REQ-030 SHALL, for bytes 0xAA, 0x00 and 0xFF, clear the matrix and both flags.
REQ-031 SHALL, for any other byte, drive map_code={e0_flag,byte} in D_LOOKUP (cycle N+1 for scan_valid at N) and sample map_* at the end of that cycle.
REQ-032 SHALL, in D_WRITE (N+2), set matrix[map_row][map_col] when brk_flag=0 and clear it when brk_flag=1; it SHALL then clear both flags.
REQ-033 SHALL make no matrix change when map_valid=0 or when map_row≥ROWS, but SHALL still clear the flags.
REQ-034 SHALL drive keydata=matrix[kbd_adr] registered, with 1-cycle read latency; a write at N+2 is visible for a read sampled at N+3.
REQ-035 SHALL give kbd_clear priority over a D_WRITE in the same cycle, zeroing all rows; the flags are unaffected.
REQ-036 SHALL hold map_code stable from D_LOOKUP through D_WRITE, and hold it at its last value otherwise.

Reset
REQ-037 SHALL, on reset, set keydata, scan_code and map_code to 0, all pulses to 0, the matrix to all 0, e0_flag, brk_flag and the skip counter to 0, the FSMs to RX_IDLE and D_IDLE, and the synchroniser and filter state to 1.
REQ-038 SHALL, when reset is asserted mid-frame, discard the partial frame with no error pulse.

Verification
REQ-039 Frame 0x1C with good parity, map returns row 2, col 1 -> scan_valid pulse, scan_code=0x1C; kbd_adr=2 gives keydata=0x02.
REQ-040 Bytes F0,1C -> kbd_adr=2 gives keydata=0x00; bytes E0,75 -> map_code=0x175 in D_LOOKUP.
REQ-041 Frame with bad parity -> err_parity pulse and no scan_valid; matrix unchanged. Stop after 5 bits -> err_frame after TIMEOUT_CYC cycles, and the next frame decodes correctly.
REQ-042 Bytes E1,14,77,E1,F0,14,F0,77 -> no matrix change and no map_code change; the following byte 0x1C decodes normally.
REQ-043 Several keys set, then byte 0xAA -> all rows read 0; kbd_clear asserted in the same cycle as D_WRITE -> the row reads 0.
REQ-044 Glitch of fewer than FILTER cycles on ps2_clk -> no bit sampled; reset mid-frame -> all outputs 0 and the next frame decodes correctly.

Source files
------------

// File: rtl/ps2_keymatrix_if.sv
// Bundle of the PS/2 lines, the key-matrix read port and the external keymap
// lookup handshake shared between the key-matrix block and its surroundings.
`timescale 1ns/1ps
interface ps2_keymatrix_if #(
    parameter int ROWS = 16,
    parameter int COLS = 8
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic             ps2_clk;
    logic             ps2_data;
    logic [ROW_W-1:0] kbd_adr;
    logic [COLS-1:0]  keydata;
    logic [8:0]       map_code;
    logic [ROW_W-1:0] map_row;
    logic [COL_W-1:0] map_col;
    logic             map_valid;
    logic             kbd_clear;
    logic             scan_valid;
    logic [7:0]       scan_code;
    logic             err_parity;
    logic             err_frame;

    // Host side: drives the PS/2 lines, the read address and the keymap answers.
    modport master (
        output ps2_clk, ps2_data, kbd_adr, map_row, map_col, map_valid, kbd_clear,
        input  keydata, map_code, scan_valid, scan_code, err_parity, err_frame
    );

    // Key-matrix side.
    modport slave (
        input  ps2_clk, ps2_data, kbd_adr, map_row, map_col, map_valid, kbd_clear,
        output keydata, map_code, scan_valid, scan_code, err_parity, err_frame
    );
endinterface

// File: rtl/ps2_keymatrix.sv
// PS/2 keyboard receiver feeding a ROWS x COLS key matrix. Bytes are framed,
// checked, then decoded (E0/F0 prefixes, Pause skip, reset bytes) and turned
// into set/clear operations on the matrix via an external keymap lookup.
`timescale 1ns/1ps
module ps2_keymatrix #(
    parameter int ROWS        = 16,
    parameter int COLS        = 8,
    parameter int TIMEOUT_CYC = 50000,
    parameter int FILTER      = 4
) (
    input  logic          clk,
    input  logic          reset,
    ps2_keymatrix_if.slave bus
);
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int FILT_W = $clog2(FILTER + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYC + 1);

    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_CYC);
    localparam logic [ROW_W:0]    ROW_LIMIT = (ROW_W + 1)'(ROWS);
    localparam logic [COL_W:0]    COL_LIMIT = (COL_W + 1)'(COLS);

    typedef enum logic [1:0] {RX_IDLE, RX_SHIFT, RX_CHECK} rxState_t;
    typedef enum logic [1:0] {D_IDLE, D_LOOKUP, D_WRITE} decState_t;

    logic [1:0]        r_clkSync;
    logic [1:0]        r_dataSync;
    logic              r_clkFilt;
    logic [FILT_W-1:0] r_filtCnt;

    rxState_t          r_rxState;
    logic [9:0]        r_shift;
    logic [3:0]        r_bitCnt;
    logic [TO_W-1:0]   r_toCnt;
    logic              r_scanValid;
    logic [7:0]        r_scanCode;
    logic              r_errParity;
    logic              r_errFrame;

    decState_t         r_decState;
    logic              r_e0Flag;
    logic              r_brkFlag;
    logic [2:0]        r_skipCnt;
    logic [8:0]        r_mapCode;
    logic [ROW_W-1:0]  r_mapRow;
    logic [COL_W-1:0]  r_mapCol;
    logic              r_mapHit;

    logic [COLS-1:0]   r_matrix [ROWS];
    logic [COLS-1:0]   r_keydata;

    logic w_clkS;
    logic w_dataS;
    logic w_filtFlip;
    logic w_fall;
    logic w_newByte;
    logic w_isResetByte;
    logic w_wipe;
    logic w_doWrite;

    assign w_clkS     = r_clkSync[1];
    assign w_dataS    = r_dataSync[1];
    assign w_filtFlip = (w_clkS != r_clkFilt) && (r_filtCnt == FILT_LAST);
    assign w_fall     = w_filtFlip && r_clkFilt;

    assign w_newByte     = (r_decState == D_IDLE) && r_scanValid && (r_skipCnt == 3'd0);
    assign w_isResetByte = (r_scanCode == 8'hAA) || (r_scanCode == 8'h00) || (r_scanCode == 8'hFF);
    assign w_wipe        = bus.kbd_clear || (w_newByte && w_isResetByte);
    assign w_doWrite     = (r_decState == D_WRITE) && r_mapHit;

    // Two-flop synchronisers for both PS/2 lines; idle level of the bus is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clkSync  <= 2'b11;
            r_dataSync <= 2'b11;
        end else begin
            r_clkSync  <= {r_clkSync[0], bus.ps2_clk};
            r_dataSync <= {r_dataSync[0], bus.ps2_data};
        end
    end

    // Deglitch ps2_clk: the filtered level only follows after FILTER agreeing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clkFilt <= 1'b1;
            r_filtCnt <= '0;
        end else if (w_clkS == r_clkFilt) begin
            r_filtCnt <= '0;
        end else if (w_filtFlip) begin
            r_clkFilt <= w_clkS;
            r_filtCnt <= '0;
        end else begin
            r_filtCnt <= r_filtCnt + 1'b1;
        end
    end

    // Frame receiver: start bit, 8 data bits LSB first, odd parity, stop bit, with an inter-edge timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxState   <= RX_IDLE;
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_toCnt     <= '0;
            r_scanValid <= 1'b0;
            r_scanCode  <= '0;
            r_errParity <= 1'b0;
            r_errFrame  <= 1'b0;
        end else begin
            r_scanValid <= 1'b0;
            r_errParity <= 1'b0;
            r_errFrame  <= 1'b0;
            case (r_rxState)
                RX_IDLE: begin
                    r_toCnt <= '0;
                    if (w_fall) begin
                        if (!w_dataS) begin
                            r_rxState <= RX_SHIFT;
                            r_bitCnt  <= '0;
                        end else begin
                            r_errFrame <= 1'b1;
                        end
                    end
                end
                RX_SHIFT: begin
                    if (w_fall) begin
                        r_shift <= {w_dataS, r_shift[9:1]};
                        r_toCnt <= '0;
                        if (r_bitCnt == 4'd9) begin
                            r_rxState <= RX_CHECK;
                        end else begin
                            r_bitCnt <= r_bitCnt + 4'd1;
                        end
                    end else if (r_toCnt == TO_LIMIT) begin
                        r_errFrame <= 1'b1;
                        r_rxState  <= RX_IDLE;
                    end else begin
                        r_toCnt <= r_toCnt + 1'b1;
                    end
                end
                RX_CHECK: begin
                    r_rxState <= RX_IDLE;
                    if (!r_shift[9]) begin
                        r_errFrame <= 1'b1;
                    end else if (!(^r_shift[8:0])) begin
                        r_errParity <= 1'b1;
                    end else begin
                        r_scanValid <= 1'b1;
                        r_scanCode  <= r_shift[7:0];
                    end
                end
                default: r_rxState <= RX_IDLE;
            endcase
        end
    end

    // Byte decoder: tracks prefixes and the Pause skip, and sequences the keymap lookup and matrix write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_decState <= D_IDLE;
            r_e0Flag   <= 1'b0;
            r_brkFlag  <= 1'b0;
            r_skipCnt  <= '0;
            r_mapCode  <= '0;
            r_mapRow   <= '0;
            r_mapCol   <= '0;
            r_mapHit   <= 1'b0;
        end else begin
            case (r_decState)
                D_IDLE: begin
                    if (r_scanValid) begin
                        if (r_skipCnt != 3'd0) begin
                            r_skipCnt <= r_skipCnt - 3'd1;
                        end else if (r_scanCode == 8'hE0) begin
                            r_e0Flag <= 1'b1;
                        end else if (r_scanCode == 8'hF0) begin
                            r_brkFlag <= 1'b1;
                        end else if (r_scanCode == 8'hE1) begin
                            r_skipCnt <= 3'd7;
                        end else if (w_isResetByte) begin
                            r_e0Flag  <= 1'b0;
                            r_brkFlag <= 1'b0;
                        end else begin
                            r_mapCode  <= {r_e0Flag, r_scanCode};
                            r_decState <= D_LOOKUP;
                        end
                    end
                end
                D_LOOKUP: begin
                    r_mapRow   <= bus.map_row;
                    r_mapCol   <= bus.map_col;
                    r_mapHit   <= bus.map_valid &&
                                  ({1'b0, bus.map_row} < ROW_LIMIT) &&
                                  ({1'b0, bus.map_col} < COL_LIMIT);
                    r_decState <= D_WRITE;
                end
                D_WRITE: begin
                    r_e0Flag   <= 1'b0;
                    r_brkFlag  <= 1'b0;
                    r_decState <= D_IDLE;
                end
                default: r_decState <= D_IDLE;
            endcase
        end
    end

    // Key matrix storage: a clear (external or reset byte) wins over a make/break write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ROWS; i++) begin
                r_matrix[i] <= '0;
            end
        end else if (w_wipe) begin
            for (int i = 0; i < ROWS; i++) begin
                r_matrix[i] <= '0;
            end
        end else if (w_doWrite) begin
            r_matrix[r_mapRow][r_mapCol] <= ~r_brkFlag;
        end
    end

    // Registered row read port; out-of-range addresses read as all released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_keydata <= '0;
        end else if ({1'b0, bus.kbd_adr} < ROW_LIMIT) begin
            r_keydata <= r_matrix[bus.kbd_adr];
        end else begin
            r_keydata <= '0;
        end
    end

    assign bus.keydata    = r_keydata;
    assign bus.map_code   = r_mapCode;
    assign bus.scan_valid = r_scanValid;
    assign bus.scan_code  = r_scanCode;
    assign bus.err_parity = r_errParity;
    assign bus.err_frame  = r_errFrame;
endmodule

// File: tb/tb_ps2_keymatrix.sv
// Directed bench for ps2_keymatrix: sends PS/2 frames bit by bit, answers keymap
// lookups from a small fixed table and reads matrix rows back.
`timescale 1ns/1ps
module tb_ps2_keymatrix;
    localparam int ROWS        = 16;
    localparam int COLS        = 8;
    localparam int TIMEOUT_CYC = 200;
    localparam int FILTER      = 4;
    localparam int HALF        = 20;

    logic clk;
    logic reset;

    int totalChecks;
    int passChecks;
    int nScan;
    int nParity;
    int nFrame;
    bit clrSeen;
    int clrWait;

    ps2_keymatrix_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

    ps2_keymatrix #(
        .ROWS(ROWS), .COLS(COLS), .TIMEOUT_CYC(TIMEOUT_CYC), .FILTER(FILTER)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running system clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed keymap: a handful of codes with known row/column positions.
    always_comb begin
        bus.map_valid = 1'b0;
        bus.map_row   = '0;
        bus.map_col   = '0;
        case (bus.map_code)
            9'h01C: begin bus.map_valid = 1'b1; bus.map_row = 4'd2; bus.map_col = 3'd1; end
            9'h175: begin bus.map_valid = 1'b1; bus.map_row = 4'd5; bus.map_col = 3'd3; end
            9'h01B: begin bus.map_valid = 1'b1; bus.map_row = 4'd3; bus.map_col = 3'd0; end
            9'h023: begin bus.map_valid = 1'b1; bus.map_row = 4'd7; bus.map_col = 3'd7; end
            9'h014: begin bus.map_valid = 1'b1; bus.map_row = 4'd4; bus.map_col = 3'd2; end
            9'h077: begin bus.map_valid = 1'b1; bus.map_row = 4'd6; bus.map_col = 3'd4; end
            default: ;
        endcase
    end

    // Count output pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.scan_valid) nScan++;
            if (bus.err_parity) nParity++;
            if (bus.err_frame)  nFrame++;
        end
    end

    // Overall time limit so the run can never hang.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        totalChecks++;
        if (got === exp) begin
            passChecks++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // mode: 0 good, 1 bad parity, 2 stop after 5 bits, 3 glitch in bit 3, 4 bad stop, 5 reset after 5 bits
    task automatic applyStimulus(input logic [7:0] b, input int mode);
        logic [10:0] frameBits;
        logic        par;
        logic        stopBit;
        int          nBits;
        par     = ~^b;
        if (mode == 1) par = ~par;
        stopBit = (mode == 4) ? 1'b0 : 1'b1;
        frameBits = {stopBit, par, b, 1'b0};
        nBits = (mode == 2 || mode == 5) ? 5 : 11;
        for (int i = 0; i < nBits; i++) begin
            bus.ps2_data = frameBits[i];
            if (mode == 3 && i == 3) begin
                waitCycles(10);
                bus.ps2_clk = 1'b0;
                waitCycles(2);
                bus.ps2_clk = 1'b1;
                waitCycles(HALF - 12);
            end else begin
                waitCycles(HALF);
            end
            bus.ps2_clk = 1'b0;
            waitCycles(HALF);
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
        if (mode == 5) begin
            waitCycles(3);
            reset = 1'b1;
            waitCycles(5);
            reset = 1'b0;
        end
        waitCycles(20);
    endtask

    task automatic readRow(input logic [3:0] adr, input logic [7:0] exp, input string tag);
        bus.kbd_adr = adr;
        waitCycles(3);
        @(negedge clk);
        checkOutput(tag, 32'(bus.keydata), 32'(exp));
    endtask

    initial begin
        totalChecks   = 0;
        passChecks    = 0;
        nScan         = 0;
        nParity       = 0;
        nFrame        = 0;
        reset         = 1'b1;
        bus.ps2_clk   = 1'b1;
        bus.ps2_data  = 1'b1;
        bus.kbd_adr   = '0;
        bus.kbd_clear = 1'b0;
        waitCycles(5);
        reset = 1'b0;
        waitCycles(2);
        @(negedge clk);
        checkOutput("rstKeydata",   32'(bus.keydata),    32'h0);
        checkOutput("rstScanCode",  32'(bus.scan_code),  32'h0);
        checkOutput("rstMapCode",   32'(bus.map_code),   32'h0);
        checkOutput("rstScanValid", 32'(bus.scan_valid), 32'h0);
        checkOutput("rstErrParity", 32'(bus.err_parity), 32'h0);
        checkOutput("rstErrFrame",  32'(bus.err_frame),  32'h0);

        // Make code for row 2 / col 1.
        applyStimulus(8'h1C, 0);
        checkOutput("make1cCount", 32'(nScan), 32'd1);
        checkOutput("make1cCode",  32'(bus.scan_code), 32'h1C);
        checkOutput("make1cMap",   32'(bus.map_code),  32'h01C);
        readRow(4'd2, 8'h02, "make1cRow2");

        // Break, then extended make.
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h1C, 0);
        readRow(4'd2, 8'h00, "break1cRow2");
        applyStimulus(8'hE0, 0);
        applyStimulus(8'h75, 0);
        checkOutput("ext75Map", 32'(bus.map_code), 32'h175);
        readRow(4'd5, 8'h08, "ext75Row5");

        // Parity error leaves everything alone.
        applyStimulus(8'h1B, 1);
        checkOutput("parityErrCount", 32'(nParity), 32'd1);
        checkOutput("parityScanCount", 32'(nScan), 32'd5);
        checkOutput("parityScanCode", 32'(bus.scan_code), 32'h75);
        readRow(4'd3, 8'h00, "parityRow3");

        // Truncated frame times out, then a good frame decodes.
        applyStimulus(8'h1B, 2);
        waitCycles(TIMEOUT_CYC + 100);
        checkOutput("timeoutFrameErr", 32'(nFrame), 32'd1);
        applyStimulus(8'h1B, 0);
        checkOutput("afterTimeoutCode", 32'(bus.scan_code), 32'h1B);
        readRow(4'd3, 8'h01, "afterTimeoutRow3");

        // Bad stop bit.
        applyStimulus(8'h23, 4);
        checkOutput("badStopFrameErr", 32'(nFrame), 32'd2);
        readRow(4'd7, 8'h00, "badStopRow7");

        // Pause sequence is swallowed entirely.
        applyStimulus(8'hE1, 0);
        applyStimulus(8'h14, 0);
        applyStimulus(8'h77, 0);
        applyStimulus(8'hE1, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h14, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h77, 0);
        checkOutput("pauseMapHeld", 32'(bus.map_code), 32'h01B);
        readRow(4'd4, 8'h00, "pauseRow4");
        readRow(4'd6, 8'h00, "pauseRow6");
        readRow(4'd3, 8'h01, "pauseRow3");
        applyStimulus(8'h1C, 0);
        checkOutput("afterPauseMap", 32'(bus.map_code), 32'h01C);
        readRow(4'd2, 8'h02, "afterPauseRow2");

        // Several keys down, then a keyboard reset byte wipes them.
        applyStimulus(8'h23, 0);
        readRow(4'd7, 8'h80, "make23Row7");
        applyStimulus(8'hAA, 0);
        readRow(4'd2, 8'h00, "aaRow2");
        readRow(4'd3, 8'h00, "aaRow3");
        readRow(4'd5, 8'h00, "aaRow5");
        readRow(4'd7, 8'h00, "aaRow7");

        // External clear coincides with the matrix write of a make code.
        clrSeen = 1'b0;
        clrWait = 0;
        fork
            applyStimulus(8'h1C, 0);
            begin
                while (!clrSeen && clrWait < 3000) begin
                    @(negedge clk);
                    clrWait++;
                    if (bus.scan_valid) clrSeen = 1'b1;
                end
                if (clrSeen) begin
                    @(posedge clk);
                    @(posedge clk);
                    #1 bus.kbd_clear = 1'b1;
                    @(posedge clk);
                    #1 bus.kbd_clear = 1'b0;
                end
            end
        join
        checkOutput("kbdClearSeen", 32'(clrSeen), 32'd1);
        checkOutput("kbdClearCode", 32'(bus.scan_code), 32'h1C);
        readRow(4'd2, 8'h00, "kbdClearRow2");

        // Short glitch on ps2_clk mid-frame must not add a bit.
        applyStimulus(8'h1B, 3);
        checkOutput("glitchScanCount", 32'(nScan), 32'd19);
        checkOutput("glitchCode", 32'(bus.scan_code), 32'h1B);
        checkOutput("glitchFrameErr", 32'(nFrame), 32'd2);
        readRow(4'd3, 8'h01, "glitchRow3");

        // Reset in the middle of a frame.
        applyStimulus(8'h23, 5);
        waitCycles(TIMEOUT_CYC + 100);
        @(negedge clk);
        checkOutput("midRstScanCode", 32'(bus.scan_code), 32'h0);
        checkOutput("midRstMapCode",  32'(bus.map_code),  32'h0);
        checkOutput("midRstFrameErr", 32'(nFrame), 32'd2);
        checkOutput("midRstParErr",   32'(nParity), 32'd1);
        readRow(4'd3, 8'h00, "midRstRow3");
        applyStimulus(8'h1C, 0);
        checkOutput("postRstCode", 32'(bus.scan_code), 32'h1C);
        readRow(4'd2, 8'h02, "postRstRow2");

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end
endmodule
